// File: rtl/mc_control_if.sv
// Memory-side handshake bundle for mc_control: instruction and data request/ready pairs.
// The master modport is the sequencer; the slave modport is the memory side.
interface mc_control_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic MemW;

    modport master (
        output imem_req,
        output dmem_req,
        output MemW,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  MemW,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RISC-V core datapath.
// Strobes are decoded combinationally from the registered state and the IR fields.
module mc_control #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    mc_control_if.master     mem,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic [1:0]       PCsrc,
    output logic [2:0]       ImmSel,
    output logic             ALUsrc,
    output logic             RegW,
    output logic             memtoreg,
    output logic             LUItoReg,
    output logic             jumplink,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam int unsigned     WaitW    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_LIMIT - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   instret_q;
    logic [WaitW-1:0]   wait_q;
    logic               illegal_q;
    logic               bus_err_q;

    logic is_imm, is_load, is_reg, is_store, is_lui, is_jal, is_branch;
    logic legal, taken, timeout;
    logic [2:0] imm_dec;
    logic       src_dec;

    assign is_imm    = (opcode == OpImm);
    assign is_load   = (opcode == OpLoad);
    assign is_reg    = (opcode == OpReg);
    assign is_store  = (opcode == OpStore);
    assign is_lui    = (opcode == OpLui);
    assign is_jal    = (opcode == OpJal);
    assign is_branch = (opcode == OpBranch);

    assign legal = is_imm | is_load | is_reg | is_store | is_lui | is_jal |
                   (is_branch & ((funct3 == 3'b000) | (funct3 == 3'b001)));
    assign taken = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);

    // Last waiting cycle before the limit; a ready in that same cycle still wins.
    assign timeout = (WAIT_LIMIT != 0) && (wait_q == WaitLast);

    always_comb begin
        imm_dec = 3'b000;
        if (is_store) begin
            imm_dec = 3'b001;
        end else if (is_branch) begin
            imm_dec = 3'b010;
        end else if (is_lui) begin
            imm_dec = 3'b011;
        end else if (is_jal) begin
            imm_dec = 3'b100;
        end
        src_dec = is_imm | is_load | is_store | is_lui;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            instret_q <= '0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    wait_q  <= '0;
                end
                StFetch: begin
                    if (mem.imem_ready) begin
                        state_q <= StDecode;
                        wait_q  <= '0;
                    end else if (timeout) begin
                        state_q   <= StTrap;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StDecode: begin
                    if (legal) begin
                        state_q <= StExec;
                    end else begin
                        state_q   <= StTrap;
                        illegal_q <= 1'b1;
                    end
                end
                StExec: begin
                    wait_q <= '0;
                    if (is_branch || is_jal) begin
                        state_q   <= StFetch;
                        instret_q <= instret_q + CNT_W'(1);
                    end else if (is_load || is_store) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (mem.dmem_ready) begin
                        wait_q <= '0;
                        if (is_store) begin
                            state_q   <= StFetch;
                            instret_q <= instret_q + CNT_W'(1);
                        end else begin
                            state_q <= StWb;
                        end
                    end else if (timeout) begin
                        state_q   <= StTrap;
                        bus_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StWb: begin
                    state_q   <= StFetch;
                    wait_q    <= '0;
                    instret_q <= instret_q + CNT_W'(1);
                end
                StTrap: begin
                    state_q <= StTrap;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    logic imem_req_c, dmem_req_c, memw_c;

    always_comb begin
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        memw_c     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCsrc      = 2'b00;
        ImmSel     = 3'b000;
        ALUsrc     = 1'b0;
        RegW       = 1'b0;
        memtoreg   = 1'b0;
        LUItoReg   = 1'b0;
        jumplink   = 1'b0;
        unique case (state_q)
            StFetch: begin
                imem_req_c = 1'b1;
                IRWrite    = mem.imem_ready;
                PCWrite    = mem.imem_ready;
            end
            StDecode: begin
                ImmSel = imm_dec;
                ALUsrc = src_dec;
            end
            StExec: begin
                ImmSel = imm_dec;
                ALUsrc = src_dec;
                if (is_branch && taken) begin
                    PCWrite = 1'b1;
                    PCsrc   = 2'b01;
                end else if (is_jal) begin
                    PCWrite  = 1'b1;
                    PCsrc    = 2'b10;
                    RegW     = 1'b1;
                    jumplink = 1'b1;
                end
            end
            StMem: begin
                ImmSel     = imm_dec;
                ALUsrc     = src_dec;
                dmem_req_c = 1'b1;
                memw_c     = is_store;
            end
            StWb: begin
                ImmSel   = imm_dec;
                ALUsrc   = src_dec;
                RegW     = 1'b1;
                memtoreg = is_load;
                LUItoReg = is_lui;
            end
            default: begin
            end
        endcase
    end

    assign mem.imem_req = imem_req_c;
    assign mem.dmem_req = dmem_req_c;
    assign mem.MemW     = memw_c;

    assign instret = instret_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-phase state/strobe vectors checked against hand-written values.
module tb_mc_control;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned WAIT_LIMIT = 16;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    logic clk = 1'b0;
    logic reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic zero;
    logic IRWrite, PCWrite, ALUsrc, RegW, memtoreg, LUItoReg, jumplink, illegal, bus_err;
    logic [1:0] PCsrc;
    logic [2:0] ImmSel, state;
    logic [CNT_W-1:0] instret;

    mc_control_if bus ();

    mc_control #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero), .mem(bus),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCsrc(PCsrc), .ImmSel(ImmSel), .ALUsrc(ALUsrc),
        .RegW(RegW), .memtoreg(memtoreg), .LUItoReg(LUItoReg), .jumplink(jumplink),
        .illegal(illegal), .bus_err(bus_err), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [CNT_W-1:0] exp_ret;
    logic [17:0] want;
    logic [17:0] got;

    // {state, imem_req, dmem_req, MemW, IRWrite, PCWrite, PCsrc, ImmSel, ALUsrc, RegW,
    //  memtoreg, LUItoReg, jumplink}
    assign got = {state, bus.imem_req, bus.dmem_req, bus.MemW, IRWrite, PCWrite, PCsrc, ImmSel,
                  ALUsrc, RegW, memtoreg, LUItoReg, jumplink};

    function automatic logic [14:0] strobes(input logic ireq, input logic dreq, input logic memw,
                                            input logic irw, input logic pcw,
                                            input logic [1:0] pcs, input logic [2:0] imm,
                                            input logic src, input logic regw, input logic m2r,
                                            input logic lui, input logic jl);
        return {ireq, dreq, memw, irw, pcw, pcs, imm, src, regw, m2r, lui, jl};
    endfunction

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_ret = '0;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++;
        if (got !== 18'd0) begin
            n_err++; $display("FAIL reset_strobes: got %h want %h", got, 18'd0);
        end
        n_cmp++;
        if ({instret, illegal, bus_err} !== '0) begin
            n_err++; $display("FAIL reset_regs: got %h want 0", {instret, illegal, bus_err});
        end
        @(negedge clk);
        reset = 1'b0;
        opcode = OP_ADDI;
        bus.imem_ready = 1'b1;
        #1;
        n_cmp++;
        if (got !== 18'd0) begin
            n_err++; $display("FAIL idle: got %h want %h", got, 18'd0);
        end
        @(negedge clk);
        #1;
        want = {3'd1, strobes(1, 0, 0, 1, 1, 2'b00, 3'b000, 0, 0, 0, 0, 0)};
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL first_fetch: got %h want %h", got, want);
        end
        @(negedge clk);
        #1;
        want = {3'd2, strobes(0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 0, 0, 0, 0)};
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL first_decode: got %h want %h", got, want);
        end
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] imm, input logic src,
                           input logic lui, input int fetch_wait, input logic [17:0] dc,
                           input string name);
        opcode = op;
        funct3 = 3'b000;
        for (int i = 0; i <= fetch_wait; i++) begin
            bus.imem_ready = (i == fetch_wait);
            #1;
            want = {3'd1, strobes(1, 0, 0, i == fetch_wait, i == fetch_wait, 2'b00, 3'b000,
                                  0, 0, 0, 0, 0)};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL %s_fetch%0d: got %h want %h", name, i, got, want);
            end
            @(negedge clk);
        end
        #1;
        want = {3'd2, strobes(0, 0, 0, 0, 0, 2'b00, imm, src, 0, 0, 0, 0)};
        n_cmp++;
        if ((got & ~dc) !== want) begin
            n_err++; $display("FAIL %s_decode: got %h want %h", name, got & ~dc, want);
        end
        @(negedge clk);
        #1;
        want = {3'd3, strobes(0, 0, 0, 0, 0, 2'b00, imm, src, 0, 0, 0, 0)};
        n_cmp++;
        if ((got & ~dc) !== want) begin
            n_err++; $display("FAIL %s_exec: got %h want %h", name, got & ~dc, want);
        end
        @(negedge clk);
        #1;
        want = {3'd5, strobes(0, 0, 0, 0, 0, 2'b00, imm, src, 1, 0, lui, 0)};
        n_cmp++;
        if ((got & ~dc) !== want) begin
            n_err++; $display("FAIL %s_wb: got %h want %h", name, got & ~dc, want);
        end
        @(negedge clk);
        exp_ret++;
        #1;
        n_cmp++;
        if ({state, instret} !== {3'd1, exp_ret}) begin
            n_err++; $display("FAIL %s_retire: got %h want %h", name, {state, instret},
                              {3'd1, exp_ret});
        end
    endtask

    task automatic run_mem(input logic store, input int wait_n);
        logic [2:0] imm;
        imm = store ? 3'b001 : 3'b000;
        opcode = store ? OP_ST : OP_LD;
        funct3 = 3'b010;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        #1;
        want = {3'd1, strobes(1, 0, 0, 1, 1, 2'b00, 3'b000, 0, 0, 0, 0, 0)};
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL mem%0d_fetch: got %h want %h", store, got, want);
        end
        @(negedge clk);
        #1;
        want = {3'd2, strobes(0, 0, 0, 0, 0, 2'b00, imm, 1, 0, 0, 0, 0)};
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL mem%0d_decode: got %h want %h", store, got, want);
        end
        @(negedge clk);
        #1;
        want = {3'd3, strobes(0, 0, 0, 0, 0, 2'b00, imm, 1, 0, 0, 0, 0)};
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL mem%0d_exec: got %h want %h", store, got, want);
        end
        @(negedge clk);
        for (int i = 0; i <= wait_n; i++) begin
            bus.dmem_ready = (i == wait_n);
            #1;
            want = {3'd4, strobes(0, 1, store, 0, 0, 2'b00, imm, 1, 0, 0, 0, 0)};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL mem%0d_req%0d: got %h want %h", store, i, got, want);
            end
            @(negedge clk);
        end
        bus.dmem_ready = 1'b0;
        if (!store) begin
            #1;
            want = {3'd5, strobes(0, 0, 0, 0, 0, 2'b00, 3'b000, 1, 1, 1, 0, 0)};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL load_wb: got %h want %h", got, want);
            end
            @(negedge clk);
        end
        exp_ret++;
        #1;
        n_cmp++;
        if ({state, instret} !== {3'd1, exp_ret}) begin
            n_err++; $display("FAIL mem%0d_retire: got %h want %h", store, {state, instret},
                              {3'd1, exp_ret});
        end
    endtask

    task automatic run_branch(input logic [6:0] op, input logic [2:0] f3, input logic z,
                              input logic taken);
        logic [17:0] dc;
        logic [2:0]  imm;
        logic [1:0]  pcs;
        logic        jal;
        jal = (op == OP_JAL);
        imm = jal ? 3'b100 : 3'b010;
        pcs = jal ? 2'b10 : (taken ? 2'b01 : 2'b00);
        // ALUsrc is not defined for jal; PCsrc is free when a branch falls through.
        dc = (jal ? 18'h00010 : 18'h0) | (taken ? 18'h0 : 18'h00300);
        opcode = op;
        funct3 = f3;
        zero = 1'b0;
        bus.imem_ready = 1'b1;
        #1;
        want = {3'd1, strobes(1, 0, 0, 1, 1, 2'b00, 3'b000, 0, 0, 0, 0, 0)};
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL br%0d%0d_fetch: got %h want %h", f3, z, got, want);
        end
        @(negedge clk);
        #1;
        want = {3'd2, strobes(0, 0, 0, 0, 0, 2'b00, imm, 0, 0, 0, 0, 0)};
        n_cmp++;
        if ((got & ~dc) !== want) begin
            n_err++; $display("FAIL br%0d%0d_decode: got %h want %h", f3, z, got & ~dc, want);
        end
        @(negedge clk);
        zero = z;
        #1;
        want = {3'd3, strobes(0, 0, 0, 0, taken, pcs, imm, 0, jal, 0, 0, jal)};
        n_cmp++;
        if ((got & ~dc) !== want) begin
            n_err++; $display("FAIL br%0d%0d_exec: got %h want %h", f3, z, got & ~dc, want);
        end
        @(negedge clk);
        zero = 1'b0;
        exp_ret++;
        #1;
        n_cmp++;
        if ({state, instret} !== {3'd1, exp_ret}) begin
            n_err++; $display("FAIL br%0d%0d_retire: got %h want %h", f3, z, {state, instret},
                              {3'd1, exp_ret});
        end
    endtask

    task automatic test_reset_mid;
        opcode = OP_ST;
        funct3 = 3'b010;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        want = {3'd4, strobes(0, 1, 1, 0, 0, 2'b00, 3'b001, 1, 0, 0, 0, 0)};
        n_cmp++;
        if (got !== want) begin
            n_err++; $display("FAIL mid_mem: got %h want %h", got, want);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({got, instret} !== '0) begin
            n_err++; $display("FAIL mid_reset: got %h want 0", {got, instret});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_ret = '0;
    endtask

    task automatic test_illegal(input logic [6:0] op, input logic [2:0] f3, input int hold);
        opcode = op;
        funct3 = f3;
        bus.imem_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (state !== 3'd2) begin
            n_err++; $display("FAIL ill_decode: got %0d want 2", state);
        end
        @(negedge clk);
        bus.dmem_ready = 1'b1;
        for (int i = 0; i < hold; i++) begin
            #1;
            n_cmp++;
            if ({got, illegal, bus_err} !== {3'd6, 15'd0, 2'b10}) begin
                n_err++; $display("FAIL ill_trap%0d: got %h want %h", i, {got, illegal, bus_err},
                                  {3'd6, 15'd0, 2'b10});
            end
            @(negedge clk);
        end
        bus.dmem_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({state, illegal} !== 4'd0) begin
            n_err++; $display("FAIL ill_reset: got %h want 0", {state, illegal});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        exp_ret = '0;
    endtask

    task automatic test_timeout;
        opcode = OP_ADDI;
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            want = {3'd1, strobes(1, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0, 0, 0, 0)};
            n_cmp++;
            if (got !== want) begin
                n_err++; $display("FAIL to_wait%0d: got %h want %h", i, got, want);
            end
            @(negedge clk);
        end
        bus.imem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({got, bus_err, illegal} !== {3'd6, 15'd0, 2'b10}) begin
            n_err++; $display("FAIL to_trap: got %h want %h", {got, bus_err, illegal},
                              {3'd6, 15'd0, 2'b10});
        end
        do_reset();
        #1;
        n_cmp++;
        if (bus_err !== 1'b0) begin
            n_err++; $display("FAIL to_clear: got %b want 0", bus_err);
        end
        run_alu(OP_ADDI, 3'b000, 1, 0, 15, 18'h0, "to_last");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        opcode = OP_ADDI;
        funct3 = 3'b000;
        zero = 1'b0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        exp_ret = '0;
        test_reset();
        do_reset();
        run_alu(OP_ADD, 3'b000, 0, 0, 0, 18'h000E0, "add");
        run_alu(OP_ADDI, 3'b000, 1, 0, 0, 18'h0, "addi");
        run_alu(OP_LUI, 3'b011, 1, 1, 0, 18'h0, "lui");
        run_mem(1'b0, 3);
        run_mem(1'b1, 3);
        run_mem(1'b0, 0);
        run_branch(OP_BR, 3'b001, 1'b0, 1'b1);
        run_branch(OP_BR, 3'b001, 1'b1, 1'b0);
        run_branch(OP_BR, 3'b000, 1'b1, 1'b1);
        run_branch(OP_BR, 3'b000, 1'b0, 1'b0);
        run_branch(OP_JAL, 3'b000, 1'b0, 1'b1);
        run_alu(OP_ADDI, 3'b000, 1, 0, 2, 18'h0, "addi_wait");
        test_reset_mid();
        test_illegal(OP_SYS, 3'b000, 20);
        test_illegal(OP_BR, 3'b010, 3);
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
